// File: rtl/decoder.sv
// LC-3-style instruction decoder with the N/Z/P condition-code register.
// Decode is purely combinational; only the CC register holds state.
module decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [15:0] wb_data,
    output logic        negative,
    output logic        zero,
    output logic        positive,
    output logic        we_reg,
    output logic        branch,
    output logic [1:0]  alu_op,
    output logic [1:0]  ssel
);
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] SRC_SR2  = 2'b00;
    localparam logic [1:0] SRC_IMM5 = 2'b01;
    localparam logic [1:0] SRC_OFF9 = 2'b10;
    localparam logic [1:0] SRC_SR1  = 2'b11;

    logic [2:0] r_cc;          // {N, Z, P}, one-hot
    logic [3:0] w_opcode;
    logic       w_imm;
    logic [2:0] w_cc_next;

    assign w_opcode = instruction[15:12];
    assign w_imm    = instruction[5];

    always_comb begin
        we_reg = 1'b0;
        branch = 1'b0;
        alu_op = ALU_ADD;
        ssel   = SRC_SR2;
        case (w_opcode)
            OP_BR: begin
                ssel   = SRC_OFF9;
                branch = |(instruction[11:9] & r_cc);
            end
            OP_ADD: begin
                we_reg = 1'b1;
                ssel   = w_imm ? SRC_IMM5 : SRC_SR2;
            end
            OP_AND: begin
                we_reg = 1'b1;
                alu_op = ALU_AND;
                ssel   = w_imm ? SRC_IMM5 : SRC_SR2;
            end
            OP_NOT: begin
                // Register form inverts SR [8:6], routed through operand B.
                we_reg = 1'b1;
                alu_op = ALU_NOT;
                ssel   = w_imm ? SRC_IMM5 : SRC_SR1;
            end
            OP_JMP: begin
                branch = 1'b1;
                alu_op = ALU_PASS;
                ssel   = SRC_SR1;
            end
            OP_LEA: begin
                we_reg = 1'b1;
                alu_op = ALU_PASS;
                ssel   = SRC_OFF9;
            end
            default: ;
        endcase
    end

    assign w_cc_next = {wb_data[15],
                        (wb_data == 16'h0000),
                        (~wb_data[15] && (wb_data != 16'h0000))};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cc <= 3'b010;
        else if (we_reg)
            r_cc <= w_cc_next;
    end

    assign negative = r_cc[2];
    assign zero     = r_cc[1];
    assign positive = r_cc[0];
endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed plan checks plus randomized
// instructions compared every cycle against a behavioural reference.
module tb_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic [15:0] wb_data = 16'h0000;
    logic        negative, zero, positive, we_reg, branch;
    logic [1:0]  alu_op, ssel;

    int errors = 0;
    int checks = 0;

    decoder dut (
        .clk(clk), .reset(reset), .instruction(instruction), .wb_data(wb_data),
        .negative(negative), .zero(zero), .positive(positive),
        .we_reg(we_reg), .branch(branch), .alu_op(alu_op), .ssel(ssel)
    );

    always #5 clk = ~clk;

    // Reference: decode fields {we, br, alu[1:0], ssel[1:0]} from the ISA rules.
    function automatic logic [5:0] ref_dec(input logic [15:0] ins, input logic [2:0] cc);
        logic [3:0] opc;
        logic       we, br, imm;
        logic [1:0] alu, src;
        opc = ins[15:12];
        imm = ins[5];
        we  = opc inside {4'h1, 4'h5, 4'h9, 4'hE};
        br  = (opc == 4'hC) ||
              (opc == 4'h0 && ((ins[11] && cc[2]) || (ins[10] && cc[1]) || (ins[9] && cc[0])));
        if (opc == 4'h5)                      alu = 2'd1;
        else if (opc == 4'h9)                 alu = 2'd2;
        else if (opc == 4'hC || opc == 4'hE)  alu = 2'd3;
        else                                  alu = 2'd0;
        if (opc == 4'h0 || opc == 4'hE)       src = 2'd2;
        else if (opc == 4'hC)                 src = 2'd3;
        else if (opc inside {4'h1, 4'h5})     src = imm ? 2'd1 : 2'd0;
        else if (opc == 4'h9)                 src = imm ? 2'd1 : 2'd3;
        else                                  src = 2'd0;
        return {we, br, alu, src};
    endfunction

    function automatic logic [2:0] ref_cc(input logic [15:0] v);
        return {($signed(v) < 0), (v == 16'h0000), ($signed(v) > 0)};
    endfunction

    logic [2:0] m_cc = 3'b010;
    always @(posedge clk or posedge reset) begin
        if (reset)
            m_cc <= 3'b010;
        else if (ref_dec(instruction, m_cc)[5])
            m_cc <= ref_cc(wb_data);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("decode", int'({we_reg, branch, alu_op, ssel}), int'(ref_dec(instruction, m_cc)));
        chk("cc", int'({negative, zero, positive}), int'(m_cc));
    end

    task automatic drive(input logic [15:0] ins, input logic [15:0] wb);
        @(posedge clk);
        #1;
        instruction = ins;
        wb_data     = wb;
        #1;
    endtask

    logic [3:0] ops[7] = '{4'h0, 4'h1, 4'h5, 4'h9, 4'hC, 4'hE, 4'hF};

    initial begin
        #1 reset = 1'b1;
        #1 chk("reset_cc", int'({negative, zero, positive}), 2);
        @(posedge clk); #1 reset = 1'b0;

        drive(16'h043F, 16'h0000);
        chk("brz_branch", int'(branch), 1);
        chk("brz_we", int'(we_reg), 0);
        chk("brz_ssel", int'(ssel), 2);
        chk("cc_after_reset", int'({negative, zero, positive}), 2);
        drive(16'h083F, 16'h0000); chk("brn_z", int'(branch), 0);
        drive(16'h023F, 16'h0000); chk("brp_z", int'(branch), 0);
        drive(16'h0E3F, 16'h0000); chk("brnzp", int'(branch), 1);

        drive(16'h1484, 16'h8000);
        chk("add_dec", int'({we_reg, alu_op, ssel}), 5'b1_00_00);
        drive(16'h083F, 16'h8000);
        chk("cc_neg", int'({negative, zero, positive}), 4);
        chk("brn_n", int'(branch), 1);
        drive(16'h023F, 16'h8000); chk("brp_n", int'(branch), 0);

        drive(16'h16A7, 16'h8000); chk("addi_dec", int'({we_reg, alu_op, ssel}), 5'b1_00_01);
        drive(16'h54C4, 16'h8000); chk("and_dec", int'({we_reg, alu_op, ssel}), 5'b1_01_00);
        drive(16'h54E4, 16'h0005); chk("andi_dec", int'({we_reg, alu_op, ssel}), 5'b1_01_01);
        drive(16'h0000, 16'h0005); chk("cc_pos", int'({negative, zero, positive}), 1);

        drive(16'h9280, 16'h0005); chk("not_dec", int'({we_reg, alu_op, ssel}), 5'b1_10_11);
        drive(16'h9423, 16'h0005); chk("noti_dec", int'({we_reg, alu_op, ssel}), 5'b1_10_01);
        drive(16'hC100, 16'h0005);
        chk("jmp_dec", int'({we_reg, branch, ssel}), 4'b0_1_11);
        chk("jmp_alu", int'(alu_op), 3);
        drive(16'hE402, 16'h0000);
        chk("lea_dec", int'({we_reg, branch, alu_op, ssel}), 6'b1_0_11_10);
        drive(16'hF000, 16'h8000);
        chk("illegal_dec", int'({we_reg, branch, alu_op, ssel}), 0);
        chk("cc_lea_zero", int'({negative, zero, positive}), 2);
        drive(16'hF000, 16'h8000);
        chk("illegal_cc_hold", int'({negative, zero, positive}), 2);

        drive(16'h1484, 16'h8000);
        drive(16'h1484, 16'h8000);
        chk("cc_neg_again", int'({negative, zero, positive}), 4);
        #1 reset = 1'b1;
        #1 chk("async_reset", int'({negative, zero, positive}), 2);
        @(posedge clk); #1;
        chk("reset_over_clk", int'({negative, zero, positive}), 2);
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            @(posedge clk);
            #1;
            instruction = {ops[$urandom_range(0, 6)], 12'($urandom)};
            case ($urandom_range(0, 3))
                0: w = 16'h0000;
                1: w = 16'h8000 | 16'($urandom);
                default: w = 16'($urandom);
            endcase
            wb_data = w;
            if ($urandom_range(0, 49) == 0) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
        end

        @(posedge clk); #6;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Instruction decoder and condition-code (CC) unit for the 16-bit LC-3-style datapath.
- Decodes the current instruction word combinationally into ALU operation, ALU operand-B source select, register write enable and branch/jump-taken.
- Holds the N/Z/P condition-code register, which is updated from write-back data. It sits between instruction fetch and the register file/ALU.

Parameters:
- none

Ports:
- clk  input  1  system clock; CC register updates on rising edge
- reset  input  1  asynchronous, active-high reset (one clock, async active-high reset)
- instruction  input  16  current instruction word
- wb_data  input  16  value being written to the register file this cycle; sets CC
- negative  output  1  CC register N bit
- zero  output  1  CC register Z bit
- positive  output  1  CC register P bit
- we_reg  output  1  register-file write enable
- branch  output  1  PC loads target this cycle (taken BR or JMP)
- alu_op  output  2  00 ADD, 01 AND, 10 NOT B, 11 PASS B
- ssel  output  2  ALU operand-B select: 00 SR2 reg [2:0], 01 SEXT(imm5 [4:0]), 10 SEXT(PCoffset9 [8:0]), 11 SR1/BaseR reg [8:6]

Behaviour:
- Opcode is instruction[15:12]. All decode outputs are purely combinational from instruction and the CC register, with zero latency.
- BR (0000): we_reg=0, alu_op=00, ssel=10. branch = |(instruction[11:9] & {N,Z,P}). nzp=000 gives branch=0 (nop); nzp=111 gives branch=1 always.
- ADD (0001): we_reg=1, alu_op=00, branch=0. instruction[5]=0 gives ssel=00; instruction[5]=1 gives ssel=01.
- AND (0101): as ADD but alu_op=01.
- NOT (1001): we_reg=1, alu_op=10, branch=0. instruction[5]=0 gives ssel=11 (invert SR [8:6]); instruction[5]=1 gives ssel=01 (invert SEXT imm5).
- JMP (1100): branch=1 unconditionally, ssel=11 (BaseR [8:6]), we_reg=0, alu_op=11.
- LEA (1110): we_reg=1, alu_op=11, ssel=10, branch=0.
- Any other opcode: we_reg=0, branch=0, alu_op=00, ssel=00. CC is not affected.
- CC register:
  - 3 bits, exactly one-hot at all times.
  - Reset (async, immediate) sets N=0, Z=1, P=0.
  - On a rising clk edge with we_reg=1, CC is loaded from wb_data:
    - N = wb_data[15]
    - Z = (wb_data == 0)
    - P = otherwise
  - With we_reg=0, CC holds.
- branch uses the CC value before the edge: a BR in the same cycle as a CC-setting instruction is impossible; a BR in the following cycle sees the new CC.
- Reset asserted mid-operation overrides any simultaneous clock update.
- negative/zero/positive outputs are driven directly from the CC register.

Test Plan:
- Reset, then apply brz 0x043F -> branch=1, we_reg=0, ssel=10. brn 0x083F -> branch=0. brp 0x023F -> branch=0. brnzp 0x0E3F -> branch=1. CC outputs read 0/1/0.
- add 0x1484 with wb_data=0x8000, one clk -> before the edge we_reg=1, alu_op=00, ssel=00; after the edge negative=1, zero=0, positive=0. Then brn 0x083F -> branch=1, brp 0x023F -> branch=0.
- addi 0x16A7 -> alu_op=00, ssel=01, we_reg=1. and 0x54C4 -> alu_op=01, ssel=00. andi 0x54E4 -> alu_op=01, ssel=01. With wb_data=0x0005 clocked -> positive=1.
- not 0x9280 -> alu_op=10, ssel=11, we_reg=1. noti 0x9423 -> alu_op=10, ssel=01, we_reg=1.
- jmp 0xC100 -> branch=1, ssel=11, we_reg=0. lea 0xE402 -> alu_op=11, ssel=10, we_reg=1, branch=0. Opcode 0xF000 -> all outputs 0 and CC unchanged after clk.
- Assert reset asynchronously between edges while CC=N -> CC becomes Z immediately. Clock with reset held and we_reg=1, wb_data=0x8000 -> CC stays Z.
